// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative radix-2 multiply/divide unit with HI/LO registers
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    input  logic             hiwe,
    input  logic             lowe,
    input  logic [WIDTH-1:0] wd,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic             neg_q, neg_d;
    logic             rsn_q, rsn_d;
    logic             bz_q, bz_d;
    logic [WIDTH-1:0] mb_q, mb_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] mul_add;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rsn_q    <= 1'b0;
            bz_q     <= 1'b0;
            mb_q     <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rsn_q    <= rsn_d;
            bz_q     <= bz_d;
            mb_q     <= mb_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rsn_d    = rsn_q;
        bz_d     = bz_q;
        mb_d     = mb_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dz_d     = 1'b0;

        a_neg    = ~op[0] & a[WIDTH-1];
        b_neg    = ~op[0] & b[WIDTH-1];

        // Multiply: rem_q is the running upper half, quo_q shifts the multiplier out
        // while product bits shift in from the top.
        mul_add  = quo_q[0] ? mb_q : '0;
        mul_sum  = {1'b0, rem_q} + {1'b0, mul_add};

        // Divide: a remainder below the divisor always fits WIDTH bits, so the
        // subtraction only needs the low WIDTH bits once the compare has passed.
        div_sh   = {rem_q, quo_q[WIDTH-1]};
        div_ge   = div_sh >= {1'b0, mb_q};
        div_diff = div_sh[WIDTH-1:0] - mb_q;

        prod     = neg_q ? -{rem_q, quo_q} : {rem_q, quo_q};
        quo_fix  = (neg_q && !bz_q) ? -quo_q : quo_q;
        rem_fix  = rsn_q ? -rem_q : rem_q;

        case (state_q)
            S_IDLE: begin
                if (hiwe) hi_d = wd;
                if (lowe) lo_d = wd;
                if (start) begin
                    is_div_d = op[1];
                    neg_d    = a_neg ^ b_neg;
                    rsn_d    = a_neg;
                    bz_d     = (b == '0);
                    quo_d    = a_neg ? -a : a;
                    mb_d     = b_neg ? -b : b;
                    rem_d    = '0;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                if (cancel) begin
                    state_d = S_IDLE;
                end else begin
                    if (is_div_q) begin
                        rem_d = div_ge ? div_diff : div_sh[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], div_ge};
                    end else begin
                        rem_d = mul_sum[WIDTH:1];
                        quo_d = {mul_sum[0], quo_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!cancel) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        // Zero divisor leaves |a| in the remainder, so the dividend-sign
                        // correction reproduces a exactly.
                        hi_d = rem_fix;
                        lo_d = bz_q ? '1 : quo_fix;
                        dz_d = bz_q;
                    end else begin
                        hi_d = prod[2*WIDTH-1:WIDTH];
                        lo_d = prod[WIDTH-1:0];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign dz   = dz_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// tb/tb_mdu_iter.sv - randomized self-checking bench for mdu_iter against an arithmetic model
module tb_mdu_iter;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        cancel;
    logic        hiwe, lowe;
    logic [31:0] wd;
    logic        busy, done, dz;
    logic [31:0] hi, lo;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [31:0] pre_hi, pre_lo, e_hi, e_lo;
    logic        e_dz;

    mdu_iter #(.WIDTH(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .cancel (cancel),
        .hiwe   (hiwe),
        .lowe   (lowe),
        .wd     (wd),
        .busy   (busy),
        .done   (done),
        .dz     (dz),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic ref_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                             output logic [31:0] rh, output logic [31:0] rl, output logic rdz);
        longint      sp;
        logic [63:0] up;
        int          sx, sy;
        rdz = 1'b0;
        sx  = x;
        sy  = y;
        case (o)
            2'b00: begin
                sp = longint'(sx) * longint'(sy);
                {rh, rl} = sp;
            end
            2'b01: begin
                up = {32'd0, x} * {32'd0, y};
                {rh, rl} = up;
            end
            default: begin
                if (y == 32'd0) begin
                    rh  = x;
                    rl  = 32'hFFFF_FFFF;
                    rdz = 1'b1;
                end else if (o == 2'b10 && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    rh = 32'd0;
                    rl = 32'h8000_0000;
                end else if (o == 2'b10) begin
                    rl = sx / sy;
                    rh = sx % sy;
                end else begin
                    rl = x / y;
                    rh = x % y;
                end
            end
        endcase
    endtask

    task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 0;
        pre_hi = hi;
        pre_lo = lo;
        ref_model(o, x, y, e_hi, e_lo, e_dz);
    endtask

    task automatic finish_op(input string tag);
        logic stable;
        stable = 1'b1;
        while (busy && cyc < 200) begin
            if (hi !== pre_hi || lo !== pre_lo || done || dz) stable = 1'b0;
            tick();
        end
        chk({tag, "_latency"}, cyc, 33);
        chk({tag, "_hold"}, stable, 1'b1);
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_hi"}, hi, e_hi);
        chk({tag, "_lo"}, lo, e_lo);
        chk({tag, "_dz"}, dz, e_dz);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'd1;
            4:       return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic flag;
        reset  = 1'b0;
        start  = 1'b0;
        op     = 2'b00;
        a      = '0;
        b      = '0;
        cancel = 1'b0;
        hiwe   = 1'b0;
        lowe   = 1'b0;
        wd     = '0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dz", dz, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        finish_op("multu_max");
        chk("multu_max_hi_const", hi, 32'hFFFF_FFFE);
        chk("multu_max_lo_const", lo, 32'h0000_0001);
        tick();
        chk("done_pulse_drop", done, 0);

        launch(2'b00, 32'hFFFF_FFFD, 32'd7);
        finish_op("mult_neg");
        chk("mult_neg_lo_const", lo, 32'hFFFF_FFEB);
        launch(2'b10, 32'hFFFF_FFF9, 32'd2);
        finish_op("div_neg");
        launch(2'b11, 32'd7, 32'd2);
        finish_op("divu_7_2");
        launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        finish_op("div_ovf");
        launch(2'b11, 32'd7, 32'd0);
        finish_op("divu_dz");
        chk("divu_dz_flag_const", dz, 1'b1);
        tick();
        chk("dz_drop", dz, 0);

        for (int i = 0; i < 24; i++) begin
            launch(2'($urandom_range(0, 3)), pick(), pick());
            finish_op($sformatf("rand%0d", i));
            if ($urandom_range(0, 1) == 0) begin
                tick();
                chk($sformatf("rand%0d_idle_done", i), {done, dz}, 2'b00);
            end
        end

        launch(2'b01, 32'd100, 32'd200);
        while (cyc < 4) tick();
        op    = 2'b10;
        a     = 32'd55;
        b     = 32'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        finish_op("ignored_start");

        tick();
        hiwe = 1'b1;
        wd   = 32'h1234_5678;
        tick();
        hiwe = 1'b0;
        chk("mthi", hi, 32'h1234_5678);
        lowe = 1'b1;
        wd   = 32'h0BAD_F00D;
        tick();
        lowe = 1'b0;
        chk("mtlo", lo, 32'h0BAD_F00D);
        chk("mtlo_hi_kept", hi, 32'h1234_5678);

        launch(2'b10, 32'd1000, 32'd7);
        while (cyc < 3) tick();
        hiwe = 1'b1;
        lowe = 1'b1;
        wd   = 32'hDEAD_BEEF;
        tick();
        hiwe = 1'b0;
        lowe = 1'b0;
        finish_op("mt_busy");

        hiwe = 1'b1;
        wd   = 32'hCAFE_0001;
        launch(2'b00, 32'd5, 32'hFFFF_FFFE);
        hiwe = 1'b0;
        chk("mt_start_hi", hi, 32'hCAFE_0001);
        finish_op("mt_start");

        launch(2'b11, 32'd9, 32'd4);
        finish_op("b2b_first");
        launch(2'b00, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        finish_op("b2b_second");

        tick();
        launch(2'b10, 32'h0001_0000, 32'd3);
        while (cyc < 10) tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        chk("cancel_busy", busy, 0);
        chk("cancel_done", {done, dz}, 2'b00);
        chk("cancel_hi", hi, pre_hi);
        chk("cancel_lo", lo, pre_lo);
        flag = 1'b0;
        repeat (40) begin
            tick();
            if (done || busy) flag = 1'b1;
        end
        chk("cancel_no_done", flag, 1'b0);

        cancel = 1'b1;
        launch(2'b11, 32'd50, 32'd5);
        cancel = 1'b0;
        finish_op("start_beats_cancel");

        launch(2'b10, 32'h8000_0001, 32'd3);
        while (cyc < 15) tick();
        #2;
        reset = 1'b0;
        #1;
        chk("async_busy", busy, 0);
        chk("async_done", done, 0);
        chk("async_dz", dz, 0);
        chk("async_hi", hi, 0);
        chk("async_lo", lo, 0);
        tick();
        reset = 1'b1;
        tick();
        launch(2'b01, 32'd2, 32'd3);
        finish_op("post_reset");
        chk("post_reset_lo_const", lo, 32'd6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
